// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 MMIO receiver: frame FSM encoding,
// the CPU load address of the receive register, rd_data bit positions
// and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [31:0] RD_ADDR = 32'd4098;

  localparam int RD_BIT_VALID = 8;
  localparam int RD_BIT_OVF   = 9;
  localparam int RD_BIT_FERR  = 10;

  // Odd parity holds when data bits plus parity bit contain an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO: DEPTH entries (power of two), pointers wrap naturally,
// simultaneous push and pop are both honoured, even when full.
module ps2_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ps2_mmio_rx.sv
// PS/2 keyboard receiver with a memory-mapped read register.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames failing
// odd parity are dropped and flagged; otherwise the parity bit is ignored.
module ps2_mmio_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic            r_clk_s1, r_clk_s2, r_clk_prev;
  logic            r_dat_s1, r_dat_s2;
  ps2_state_t      r_state, w_state_nxt;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_overflow, r_frame_err;
  logic            w_fall, w_timeout, w_push, w_frame_err, w_parity_ok;
  logic            w_empty, w_full, w_drop;
  logic [7:0]      w_head;

`ifdef PS2_PARITY_CHECK_EN
  logic            r_parity;
  assign w_parity_ok = odd_parity_ok(r_shift, r_parity);
`else
  assign w_parity_ok = 1'b1;
`endif

  // Two-flop synchronizers plus a history flop for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev && !r_clk_s2;
  assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Frame FSM next state, push request and frame error events.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_frame_err = 1'b1;
    end else if (w_fall) begin
      unique case (r_state)
        ST_IDLE:   if (!r_dat_s2) w_state_nxt = ST_DATA;
        ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (r_dat_s2 && w_parity_ok) w_push      = 1'b1;
          else                         w_frame_err = 1'b1;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state, bit counter and inactivity timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_fall && r_state == ST_IDLE)      r_bit_cnt <= '0;
      else if (w_fall && r_state == ST_DATA) r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Data capture: LSB arrives first, so shift in from the top.
  always_ff @(posedge clock) begin
    if (w_fall && r_state == ST_DATA) r_shift <= {r_dat_s2, r_shift[7:1]};
`ifdef PS2_PARITY_CHECK_EN
    if (w_fall && r_state == ST_PARITY) r_parity <= r_dat_s2;
`endif
  end

  ps2_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (rd_en),
    .i_data  (r_shift),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_drop = w_push && w_full && !(rd_en && !w_empty);

  // Sticky status flags: a read clears them, a new event on the same edge wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (rd_en) begin
        r_overflow  <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_drop)      r_overflow  <= 1'b1;
      if (w_frame_err) r_frame_err <= 1'b1;
    end
  end

  // Read word assembly; the head byte is masked while the FIFO is empty.
  always_comb begin
    rd_data               = '0;
    rd_data[7:0]          = w_empty ? 8'h00 : w_head;
    rd_data[RD_BIT_VALID] = !w_empty;
    rd_data[RD_BIT_OVF]   = r_overflow;
    rd_data[RD_BIT_FERR]  = r_frame_err;
  end

  assign irq = !w_empty;

endmodule

// File: doc/ps2_mmio_rx.md
PS2_MMIO_RX -- requirements
Module: ps2_mmio_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, scan-code FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, clock cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from pad, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from pad, asynchronous.
REQ-007 SHALL have port rd_en  input  1  CPU read strobe, high one cycle when the load address decodes to 4098.
REQ-008 SHALL have port rd_data  output  32  read word: [7:0] head code, [8] valid, [9] overflow, [10] frame_err, [31:11] zero.
REQ-009 SHALL have port irq  output  1  high while the FIFO is non-empty.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before use.
REQ-011 SHALL detect a PS/2 falling edge as synchronized clk previous=1, current=0; all bit sampling SHALL occur on that cycle only.
REQ-012 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, one transition per falling edge.
REQ-013 IDLE: data=0 at an edge -> DATA with bit count 0; data=1 -> stay IDLE (glitch start ignored).
REQ-014 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-015 PARITY: capture parity bit -> STOP.
REQ-016 STOP: stop bit 1 and frame accepted -> push byte into FIFO; stop bit 0 -> set frame_err, no push; either case -> IDLE.
REQ-017 SHALL count cycles since the last edge in any non-IDLE state; reaching TIMEOUT_CYC -> IDLE, set frame_err, discard partial byte.
REQ-018 rd_data[7:0] SHALL be combinational from the FIFO head, 0 when empty; [8]=not empty; zero-cycle read latency.
REQ-019 rd_en with FIFO non-empty SHALL pop the head at that clock edge; rd_en on empty SHALL not change the FIFO.
REQ-020 rd_en SHALL clear overflow and frame_err at the same edge, after their values are presented on rd_data.
REQ-021 A push with FIFO full and no pop SHALL drop the new byte and set overflow; contents unchanged.
REQ-022 A push and a pop in the same cycle SHALL both take effect, including when full; the count is unchanged.
REQ-023 A new error event in the same cycle as rd_en SHALL leave its flag set (set wins over clear).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.

Reset
REQ-025 reset SHALL force FSM to IDLE, FIFO empty, pointers 0, flags 0, timeout counter 0 and synchronizers 1, giving rd_data=0 and irq=0 on the following cycle.
REQ-026 reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL be received normally.

Configuration
REQ-027 With PS2_PARITY_CHECK_EN defined: odd parity over 8 data bits and the parity bit is checked; on mismatch the byte is not pushed and frame_err is set.
REQ-028 Without PS2_PARITY_CHECK_EN: the parity bit is sampled and ignored; only the stop bit gates the push.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the FSM state encoding, the MMIO address constant 4098 and the rd_data bit-position constants.
REQ-030 The FIFO SHALL be sub-module ps2_fifo (push/pop/full/empty/head); the frame FSM stays in ps2_mmio_rx.

Verification
REQ-031 Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 10 kHz PS/2 clock -> rd_data=0x0000011C, irq=1; rd_en -> rd_data=0, irq=0.
REQ-032 Five frames 0x01..0x05 with DEPTH 4 and no reads -> four reads return 0x101..0x104 with bit 9 set on the first; fifth byte lost.
REQ-033 With PS2_PARITY_CHECK_EN, frame 0x1C with parity 1 -> nothing pushed; rd_data=0x400; rd_en clears the flag to 0.
REQ-034 Stop after 5 data bits, idle TIMEOUT_CYC cycles -> FSM IDLE, frame_err=1; next frame 0xF0 -> rd_data[8:0]=0x1F0.
REQ-035 FIFO full with rd_en coincident with a new 0xAA push -> count stays 4, oldest popped, 0xAA at tail, overflow 0.
REQ-036 reset pulsed after 4 bits of a frame -> rd_data=0 next cycle; the following full frame 0x29 -> rd_data=0x129.
